fft16_frame_ctrl: RTL and testbench

Frame sequencer for the 16-point, 4-stage registered FFT pipeline. It accepts complex samples serially over a valid/ready stream and assembles a 16-sample frame in natural order. It then drives the FFT's parallel input buses, waits out the pipeline latency, captures the 16 results and streams them out serially in bin order.

---
 rtl/fft16_frame_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fft16_frame_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft16_frame_ctrl.sv
// fft16_frame_ctrl
// Frame sequencer wrapped around a 16-point registered FFT pipeline.
// Samples arrive serially on a valid/ready stream and are collected into a
// 16-entry frame in natural order. The frame is presented in parallel on
// fft_x_*. The controller then waits out the pipeline latency, captures
// fft_y_* into a result buffer and streams the bins out serially in bin order.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   abort               synchronous single-cycle frame abort
//   in_valid/in_ready   input sample handshake; in_re/in_im carry the sample
//   fft_x_re/fft_x_im   parallel FFT inputs, lane k = bits [k*DATA_W +: DATA_W]
//   fft_y_re/fft_y_im   parallel FFT outputs, same packing
//   out_valid/out_ready output bin handshake; out_re/out_im/out_index/out_last
//   busy                high whenever the state is not FILL
//   frame_done          one-cycle pulse after the bin-15 handshake
//
// Build option: define FFT_OUT_SHIFT_EN to apply an arithmetic right shift by
// 4 (1/16 scaling) to every captured result component. Timing is unchanged.
module fft16_frame_ctrl #(
   parameter int DATA_W      = 16,
   parameter int FFT_LATENCY = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 abort,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_re,
   input  logic [DATA_W-1:0]    in_im,
   output logic [16*DATA_W-1:0] fft_x_re,
   output logic [16*DATA_W-1:0] fft_x_im,
   input  logic [16*DATA_W-1:0] fft_y_re,
   input  logic [16*DATA_W-1:0] fft_y_im,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_re,
   output logic [DATA_W-1:0]    out_im,
   output logic [3:0]           out_index,
   output logic                 out_last,
   output logic                 busy,
   output logic                 frame_done
);

   typedef enum logic [1:0] {FILL = 2'd0, WAIT = 2'd1, DRAIN = 2'd2} state_t;

   // The wait counter must be able to reach FFT_LATENCY.
   localparam int CNT_W = (FFT_LATENCY < 1) ? 1 : $clog2(FFT_LATENCY + 1);

   state_t            state;
   logic [3:0]        wr_ptr;
   logic [3:0]        rd_ptr;
   logic [3:0]        rd_nxt;
   logic [CNT_W-1:0]  wait_cnt;

   logic [DATA_W-1:0] in_re_buf  [16];
   logic [DATA_W-1:0] in_im_buf  [16];
   logic [DATA_W-1:0] res_re_buf [16];
   logic [DATA_W-1:0] res_im_buf [16];
   logic [DATA_W-1:0] cap_re     [16];
   logic [DATA_W-1:0] cap_im     [16];

   assign rd_nxt = rd_ptr + 4'd1;

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_lane
         // The FFT sees the input buffer directly; it only changes in FILL.
         assign fft_x_re[gi*DATA_W +: DATA_W] = in_re_buf[gi];
         assign fft_x_im[gi*DATA_W +: DATA_W] = in_im_buf[gi];
`ifdef FFT_OUT_SHIFT_EN
         assign cap_re[gi] = $signed(fft_y_re[gi*DATA_W +: DATA_W]) >>> 4;
         assign cap_im[gi] = $signed(fft_y_im[gi*DATA_W +: DATA_W]) >>> 4;
`else
         assign cap_re[gi] = fft_y_re[gi*DATA_W +: DATA_W];
         assign cap_im[gi] = fft_y_im[gi*DATA_W +: DATA_W];
`endif
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FILL;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         wait_cnt   <= '0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         out_index  <= '0;
         out_re     <= '0;
         out_im     <= '0;
         for (int i = 0; i < 16; i++) begin
            in_re_buf[i]  <= '0;
            in_im_buf[i]  <= '0;
            res_re_buf[i] <= '0;
            res_im_buf[i] <= '0;
         end
      end else if (abort) begin
         // Abort takes priority over any handshake in the same cycle; buffer
         // contents are left as they are.
         state      <= FILL;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         wait_cnt   <= '0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            FILL: begin
               if (in_valid && in_ready) begin
                  in_re_buf[wr_ptr] <= in_re;
                  in_im_buf[wr_ptr] <= in_im;
                  if (wr_ptr == 4'd15) begin
                     wr_ptr   <= '0;
                     wait_cnt <= '0;
                     state    <= WAIT;
                     in_ready <= 1'b0;
                     busy     <= 1'b1;
                  end else begin
                     wr_ptr <= wr_ptr + 4'd1;
                  end
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt + CNT_W'(1);
               if (wait_cnt == CNT_W'(FFT_LATENCY)) begin
                  for (int i = 0; i < 16; i++) begin
                     res_re_buf[i] <= cap_re[i];
                     res_im_buf[i] <= cap_im[i];
                  end
                  // Bin 0 is loaded into the output register on the same
                  // edge so out_valid can rise in the first DRAIN cycle.
                  rd_ptr    <= '0;
                  state     <= DRAIN;
                  out_valid <= 1'b1;
                  out_re    <= cap_re[0];
                  out_im    <= cap_im[0];
                  out_index <= '0;
                  out_last  <= 1'b0;
               end
            end
            DRAIN: begin
               if (out_valid && out_ready) begin
                  rd_ptr <= rd_nxt;
                  if (rd_ptr == 4'd15) begin
                     state      <= FILL;
                     out_valid  <= 1'b0;
                     out_last   <= 1'b0;
                     in_ready   <= 1'b1;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                  end else begin
                     out_re    <= res_re_buf[rd_nxt];
                     out_im    <= res_im_buf[rd_nxt];
                     out_index <= rd_nxt;
                     out_last  <= (rd_nxt == 4'd15);
                  end
               end
            end
            default: begin
               state <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// tb_fft16_frame_ctrl
// Bench for fft16_frame_ctrl. A 4-stage registered DFT stands in for the FFT.
// Accepted input samples are collected by a monitor; when a frame completes,
// the expected bins (textbook DFT of the frame, optionally scaled) are queued
// and popped as the DUT hands out bins.
// Honours FFT_OUT_SHIFT_EN the same way as the design.
`timescale 1ns/1ps
module tb_fft16_frame_ctrl;
   localparam int DW  = 16;
   localparam int LAT = 4;
`ifdef FFT_OUT_SHIFT_EN
   localparam logic [15:0] DC_BIN0 = 16'h0100;
`else
   localparam logic [15:0] DC_BIN0 = 16'h1000;
`endif

   logic            clk = 1'b0;
   logic            rst_n, abort, in_valid, in_ready;
   logic [DW-1:0]   in_re, in_im;
   logic [16*DW-1:0] fft_x_re, fft_x_im, fft_y_re, fft_y_im;
   logic            out_valid, out_ready, out_last, busy, frame_done;
   logic [DW-1:0]   out_re, out_im;
   logic [3:0]      out_index;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   fft16_frame_ctrl #(.DATA_W(DW), .FFT_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
      .fft_x_re(fft_x_re), .fft_x_im(fft_x_im),
      .fft_y_re(fft_y_re), .fft_y_im(fft_y_im),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_re(out_re), .out_im(out_im), .out_index(out_index), .out_last(out_last),
      .busy(busy), .frame_done(frame_done)
   );

   // ---------------- reference arithmetic ----------------
   real cos_t [16];
   real sin_t [16];
   initial begin
      for (int m = 0; m < 16; m++) begin
         cos_t[m] = $cos(6.283185307179586 * m / 16.0);
         sin_t[m] = $sin(6.283185307179586 * m / 16.0);
      end
   end

   function automatic logic [15:0] rnd16(input real v);
      int i;
      if (v >= 0.0) i = $rtoi(v + 0.5);
      else          i = -$rtoi(0.5 - v);
      return i[15:0];
   endfunction

   // X[k] = sum_n x[n] * exp(-j*2*pi*k*n/16), rounded to nearest.
   function automatic logic [15:0] dft_bin(input logic [255:0] xr, input logic [255:0] xi,
                                           input int k, input bit want_im);
      real sr, si, ar, ai;
      logic signed [15:0] a, b;
      int m;
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 16; n++) begin
         a  = xr[n*16 +: 16];
         b  = xi[n*16 +: 16];
         ar = $itor(a);
         ai = $itor(b);
         m  = (k * n) % 16;
         sr = sr + ar * cos_t[m] + ai * sin_t[m];
         si = si + ai * cos_t[m] - ar * sin_t[m];
      end
      return want_im ? rnd16(si) : rnd16(sr);
   endfunction

   function automatic logic [15:0] scale(input logic [15:0] v);
      logic signed [15:0] t;
      t = v;
`ifdef FFT_OUT_SHIFT_EN
      t = t >>> 4;
`endif
      return t;
   endfunction

   // ---------------- FFT stand-in: DFT followed by LAT register stages ----------------
   logic [255:0] p_re [4];
   logic [255:0] p_im [4];
   always @(posedge clk) begin
      for (int k = 0; k < 16; k++) begin
         p_re[0][k*16 +: 16] <= dft_bin(fft_x_re, fft_x_im, k, 1'b0);
         p_im[0][k*16 +: 16] <= dft_bin(fft_x_re, fft_x_im, k, 1'b1);
      end
      for (int s = 1; s < 4; s++) begin
         p_re[s] <= p_re[s-1];
         p_im[s] <= p_im[s-1];
      end
   end
   assign fft_y_re = p_re[3];
   assign fft_y_im = p_im[3];

   // ---------------- check helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      $display("FAIL %s: actual timeout required DUT event within bound", name);
   endtask

   // ---------------- output-ready driver ----------------
   int rdy_mode   = 0;   // 0: always ready, 1: random, 2: one 3-cycle stall at bin 5
   int stall_left = 0;
   bit stall_done = 1'b0;
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: begin
               if (stall_left > 0) begin
                  out_ready = 1'b0;
                  stall_left--;
               end else if (!stall_done && out_valid && out_index == 4'd5) begin
                  out_ready  = 1'b0;
                  stall_left = 2;
                  stall_done = 1'b1;
               end else begin
                  out_ready = 1'b1;
               end
            end
            default: out_ready = 1'b1;
         endcase
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [36:0]  exp_q [$];          // {last, index, im, re}
   logic [255:0] fr_re, fr_im;
   logic [36:0]  mon_e, held;
   logic [15:0]  bin0_re = '0;
   int n_acc = 0, wait_left = 0, hs_cnt = 0, fd_cnt = 0, st_cnt = 0;
   bit pending = 1'b0, fd_exp = 1'b0, fd_next = 1'b0, hold_vld = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            n_acc = 0; pending = 1'b0; fd_exp = 1'b0; hold_vld = 1'b0; wait_left = 0;
         end else begin
            check("frame_done", frame_done, fd_exp);
            check("in_ready", in_ready, !pending);
            check("busy", busy, pending);
            if (pending && wait_left > 0) begin
               check("out_valid_wait", out_valid, 1'b0);
               wait_left--;
            end else begin
               check("out_valid", out_valid, pending);
            end
            if (hold_vld)
               check("stall_hold", {out_valid, out_last, out_index, out_im, out_re}, {1'b1, held});
            if (frame_done) fd_cnt++;

            hold_vld = 1'b0;
            fd_next  = 1'b0;
            if (out_valid && !out_ready && !abort) begin
               hold_vld = 1'b1;
               held     = {out_last, out_index, out_im, out_re};
               st_cnt++;
            end
            if (out_valid && out_ready && !abort) begin
               hs_cnt++;
               if (out_index == 4'd0) bin0_re = out_re;
               if (exp_q.size() == 0) begin
                  checks++;
                  $display("FAIL bin_unexpected: actual bin %0d handed out, required none", out_index);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("bin", {out_last, out_index, out_im, out_re}, mon_e);
                  if (mon_e[36]) begin
                     pending = 1'b0;
                     fd_next = 1'b1;
                  end
               end
            end
            if (in_valid && in_ready && !abort) begin
               fr_re[n_acc*16 +: 16] = in_re;
               fr_im[n_acc*16 +: 16] = in_im;
               n_acc++;
               if (n_acc == 16) begin
                  for (int k = 0; k < 16; k++)
                     exp_q.push_back({k == 15, 4'(k), scale(dft_bin(fr_re, fr_im, k, 1'b1)),
                                      scale(dft_bin(fr_re, fr_im, k, 1'b0))});
                  n_acc     = 0;
                  pending   = 1'b1;
                  wait_left = LAT + 1;
               end
            end
            if (abort) begin
               exp_q.delete();
               n_acc = 0; pending = 1'b0; fd_next = 1'b0; hold_vld = 1'b0; wait_left = 0;
            end
            fd_exp = fd_next;
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [15:0] stim_re [16];
   logic [15:0] stim_im [16];

   task automatic set_impulse();
      for (int i = 0; i < 16; i++) begin
         stim_re[i] = (i == 0) ? 16'h0001 : 16'h0000;
         stim_im[i] = 16'h0000;
      end
   endtask

   task automatic rand_stim();
      int v;
      for (int i = 0; i < 16; i++) begin
         v = int'($urandom_range(0, 2000)) - 1000;
         stim_re[i] = v[15:0];
         v = int'($urandom_range(0, 2000)) - 1000;
         stim_im[i] = v[15:0];
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that took the last sample.
   task automatic send_samples(input int n, input int gap_mode);
      int idle, t;
      for (int i = 0; i < n; i++) begin
         idle = (gap_mode == 1 && i > 0) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
         in_valid = 1'b0;
         repeat (idle) begin
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_re    = stim_re[i];
         in_im    = stim_im[i];
         t = 0;
         @(negedge clk);
         while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
         end
         if (!in_ready) begin
            fail_timeout("in_ready_wait");
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int t = 0;
      @(negedge clk);
      while (!frame_done && t < bound) begin
         @(negedge clk);
         t++;
      end
      if (!frame_done) fail_timeout("frame_done_wait");
      @(posedge clk);
      #1;
   endtask

   task automatic wait_for_index(input logic [3:0] idx);
      int t = 0;
      @(negedge clk);
      while (!(out_valid && out_index == idx) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!(out_valid && out_index == idx)) fail_timeout("out_index_wait");
   endtask

   task automatic abort_pulse();
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
   endtask

   int cnt, fd0, hs0, st0;

   initial begin
      rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_out_index", out_index, 4'd0);
      check("rst_out_data", {out_im, out_re}, 32'h0);
      check("rst_in_buf_zero", {fft_x_re == '0, fft_x_im == '0}, 2'b11);
      @(posedge clk);
      #1;

      // Impulse, back to back, timing of first bin and of return to FILL
      set_impulse();
      send_samples(16, 0);
      cnt = 16;
      @(negedge clk);
      while (!out_valid && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      check("first_out_valid_cycle", cnt, 21);
      while (!frame_done && cnt < 300) begin
         @(negedge clk);
         cnt++;
      end
      check("frame_done_cycle", cnt, 37);
      @(posedge clk);
      #1;

      // DC frame with a 3-cycle stall at bin 5
      for (int i = 0; i < 16; i++) begin
         stim_re[i] = 16'h0100;
         stim_im[i] = 16'h0000;
      end
      fd0 = fd_cnt; hs0 = hs_cnt; st0 = st_cnt;
      stall_done = 1'b0;
      rdy_mode   = 2;
      send_samples(16, 0);
      wait_done(400);
      rdy_mode = 0;
      check("dc_bin0_re", bin0_re, DC_BIN0);
      check("bp_stall_cycles", st_cnt - st0, 3);
      check("bp_bins", hs_cnt - hs0, 16);
      check("bp_frame_done_pulses", fd_cnt - fd0, 1);

      // Impulse with alternating input gaps
      set_impulse();
      send_samples(16, 1);
      wait_done(400);

      // Abort mid-fill after 7 samples, then a clean impulse frame
      rand_stim();
      send_samples(7, 0);
      abort_pulse();
      @(negedge clk);
      check("abort_fill_busy", busy, 1'b0);
      check("abort_fill_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      set_impulse();
      send_samples(16, 0);
      wait_done(400);

      // Random frames, random gaps and random backpressure
      rdy_mode = 1;
      repeat (5) begin
         rand_stim();
         send_samples(16, 2);
      end
      wait_done(600);
      rdy_mode = 0;

      // Abort mid-drain, then another frame
      rand_stim();
      send_samples(16, 0);
      wait_for_index(4'd3);
      @(posedge clk);
      #1;
      abort_pulse();
      rand_stim();
      send_samples(16, 0);
      wait_done(400);

      // Asynchronous reset mid-drain, then another frame
      rand_stim();
      send_samples(16, 0);
      wait_for_index(4'd8);
      #1 rst_n = 1'b0;
      #1;
      check("rst_drain_out_valid", out_valid, 1'b0);
      check("rst_drain_in_ready", in_ready, 1'b1);
      check("rst_drain_busy", busy, 1'b0);
      check("rst_drain_out_index", out_index, 4'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rand_stim();
      send_samples(16, 2);
      wait_done(400);

      repeat (3) @(posedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
